// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the Lapido datapath. Holds the fetch PC and
//   advances it by 4 each cycle. It also handles branch/jump loads, and it
//   handles call/return through an internal return-address stack (RAS).
//
// Parameters
//   RESET_VECTOR    PC value loaded on reset
//   RAS_DEPTH       return-address stack entries (power of 2, >= 2)
//
// Ports
//   i_clock          system clock, rising-edge
//   i_reset          synchronous active-high reset
//   i_stall          freeze PC, RAS and flags for this cycle
//   i_branch_taken   load PC from branch target, RAS untouched
//   i_call           load PC from branch target and push PC+4
//   i_ret            load PC from RAS top and pop
//   i_branch_target  destination address (low two bits ignored)
//   o_pc             current fetch address (registered)
//   o_pc_plus4       o_pc + 4, combinational, wraps modulo 2^32
//   o_ras_empty      RAS holds no entries (registered)
//   o_ras_full       RAS holds RAS_DEPTH entries (registered)
//   o_ras_error      one-cycle pulse after an illegal push/pop/combination
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          RAS_DEPTH    = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic        i_call,
  input  logic        i_ret,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_ras_empty,
  output logic        o_ras_full,
  output logic        o_ras_error
);

  localparam int IDX_W = $clog2(RAS_DEPTH);
  // Pointer counts entries 0..RAS_DEPTH, so it needs one bit more than an index.
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(RAS_DEPTH);

  logic [31:0]      r_pc;
  logic [31:0]      r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic             r_empty;
  logic             r_full;
  logic             r_error;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_target_aligned;
  logic [31:0]      w_push_value;
  logic [PTR_W-1:0] w_ptr_dec;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;

  logic [31:0]      w_pc_next;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_push;
  logic             w_error_next;

  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_target_aligned = i_branch_target & ~32'h3;
  assign w_push_value     = w_pc_plus4 & ~32'h3;
  assign w_ptr_dec        = r_ptr - PTR_W'(1);
  assign w_ptr_inc        = r_ptr + PTR_W'(1);
  assign w_top_idx        = w_ptr_dec[IDX_W-1:0];
  assign w_push_idx       = r_ptr[IDX_W-1:0];

  // Next-state selection; priority is ret > call > branch > sequential.
  always_comb begin
    w_pc_next    = w_pc_plus4;
    w_ptr_next   = r_ptr;
    w_push       = 1'b0;
    w_error_next = 1'b0;
    if (i_ret) begin
      if (r_empty) begin
        // Pop from an empty stack: fall through sequentially and flag it.
        w_error_next = 1'b1;
      end else begin
        w_pc_next  = r_ras[w_top_idx];
        w_ptr_next = w_ptr_dec;
      end
      // A simultaneous call is dropped and reported.
      if (i_call) begin
        w_error_next = 1'b1;
      end
    end else if (i_call) begin
      // The jump still happens on overflow; only the push is lost.
      w_pc_next = w_target_aligned;
      if (r_full) begin
        w_error_next = 1'b1;
      end else begin
        w_push     = 1'b1;
        w_ptr_next = w_ptr_inc;
      end
    end else if (i_branch_taken) begin
      w_pc_next = w_target_aligned;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc    <= RESET_VECTOR;
      r_ptr   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_error <= 1'b0;
    end else if (i_stall) begin
      // Everything holds except the error pulse, which must not repeat.
      r_error <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_ptr   <= w_ptr_next;
      r_empty <= (w_ptr_next == '0);
      r_full  <= (w_ptr_next == PTR_FULL);
      r_error <= w_error_next;
    end
  end

  // Stack storage has no reset: the pointer alone defines what is valid.
  always_ff @(posedge i_clock) begin
    if (!i_reset && !i_stall && w_push) begin
      r_ras[w_push_idx] <= w_push_value;
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_ras_empty = r_empty;
  assign o_ras_full  = r_full;
  assign o_ras_error = r_error;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic        call;
  logic        ret;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_error;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .RAS_DEPTH   (8)
  ) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_stall        (stall),
    .i_branch_taken (branch_taken),
    .i_call         (call),
    .i_ret          (ret),
    .i_branch_target(target),
    .o_pc           (pc),
    .o_pc_plus4     (pc_plus4),
    .o_ras_empty    (ras_empty),
    .o_ras_full     (ras_full),
    .o_ras_error    (ras_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; one tick crosses a rising edge and
  // lands on the next falling edge, where outputs are sampled.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_empty,
                           input logic e_full, input logic e_err);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, e_empty});
    chk({tag, ".full"}, {31'd0, ras_full}, {31'd0, e_full});
    chk({tag, ".err"}, {31'd0, ras_error}, {31'd0, e_err});
    $display("step %s pc=%h empty=%0b full=%0b err=%0b", tag, pc, ras_empty, ras_full, ras_error);
  endtask

  task automatic set_in(input logic s, input logic b, input logic c, input logic r,
                        input logic [31:0] t);
    stall = s; branch_taken = b; call = c; ret = r; target = t;
  endtask

  // Return addresses expected from the eight pops, most recent first.
  logic [31:0] ret_addr [8];

  initial begin
    ret_addr = '{32'h7004, 32'h6004, 32'h5004, 32'h4004,
                 32'h3004, 32'h2004, 32'h1004, 32'h0028};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    tick();
    tick();
    chk_state("t1_reset", 32'h0, 1, 0, 0);

    // T1: sequential advance
    reset = 1'b0;
    tick(); chk_state("t1_seq4", 32'h4, 1, 0, 0);
    tick(); chk_state("t1_seq8", 32'h8, 1, 0, 0);

    // T2: branch with unaligned target
    set_in(0, 1, 0, 0, 32'h103);
    tick(); chk_state("t2_branch", 32'h100, 1, 0, 0);
    set_in(0, 0, 0, 0, 32'h0);
    tick(); chk_state("t2_after", 32'h104, 1, 0, 0);

    // T3: call / ret
    set_in(0, 1, 0, 0, 32'h20);
    tick(); chk_state("t3_to20", 32'h20, 1, 0, 0);
    set_in(0, 0, 1, 0, 32'h400);
    tick(); chk_state("t3_call", 32'h400, 0, 0, 0);
    set_in(0, 0, 0, 0, 32'h0);
    tick(); chk_state("t3_idle1", 32'h404, 0, 0, 0);
    tick(); chk_state("t3_idle2", 32'h408, 0, 0, 0);
    set_in(0, 0, 0, 1, 32'h0);
    tick(); chk_state("t3_ret", 32'h24, 1, 0, 0);

    // T4: fill the stack (first target unaligned), overflow, drain, underflow
    set_in(0, 0, 1, 0, 32'h1003);
    tick(); chk_state("t4_call0", 32'h1000, 0, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      set_in(0, 0, 1, 0, 32'h1000 * i);
      tick(); chk_state($sformatf("t4_call%0d", i - 1), 32'h1000 * i, 0, (i == 8), 0);
    end
    set_in(0, 0, 1, 0, 32'h9000);
    tick(); chk_state("t4_overflow", 32'h9000, 0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      set_in(0, 0, 0, 1, 32'h0);
      tick(); chk_state($sformatf("t4_ret%0d", k), ret_addr[k], (k == 7), 0, 0);
    end
    tick(); chk_state("t4_underflow", 32'h2c, 1, 0, 1);
    set_in(0, 0, 0, 0, 32'h0);
    tick(); chk_state("t4_clear", 32'h30, 1, 0, 0);

    // T5: wrap and stall
    set_in(0, 1, 0, 0, 32'hFFFF_FFFF);
    tick(); chk_state("t5_top", 32'hFFFF_FFFC, 1, 0, 0);
    chk("t5_pc_plus4_wrap", pc_plus4, 32'h0);
    set_in(0, 0, 0, 0, 32'h0);
    tick(); chk_state("t5_wrap", 32'h0, 1, 0, 0);
    for (int s = 0; s < 3; s++) begin
      set_in(1, 0, 1, 0, 32'h500);
      tick(); chk_state($sformatf("t5_stall%0d", s), 32'h0, 1, 0, 0);
    end
    set_in(0, 0, 0, 0, 32'h0);
    tick(); chk_state("t5_unstall", 32'h4, 1, 0, 0);
    set_in(0, 0, 0, 1, 32'h0);
    tick(); chk_state("t5_errpop", 32'h8, 1, 0, 1);
    set_in(1, 0, 0, 1, 32'h0);
    tick(); chk_state("t5_stallerr", 32'h8, 1, 0, 0);

    // T6: call+ret conflict, then reset with entries on the stack
    set_in(0, 1, 0, 0, 32'h7C);
    tick(); chk_state("t6_to7c", 32'h7C, 1, 0, 0);
    set_in(0, 1, 1, 0, 32'h200);
    tick(); chk_state("t6_brcall", 32'h200, 0, 0, 0);
    set_in(0, 0, 1, 1, 32'h300);
    tick(); chk_state("t6_conflict", 32'h80, 1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 1, 0, 32'h10);
      tick(); chk_state($sformatf("t6_push%0d", c), 32'h10, 0, 0, 0);
    end
    reset = 1'b1;
    set_in(0, 0, 0, 0, 32'h0);
    tick(); chk_state("t6_reset", 32'h0, 1, 0, 0);
    reset = 1'b0;
    set_in(0, 0, 0, 1, 32'h0);
    tick(); chk_state("t6_retempty", 32'h4, 1, 0, 1);
    set_in(0, 0, 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
